// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one gate-level 6-bit ripple adder among N_REQ requesters.
// Operands are registered on grant and held on the adder for ADD_CYCLES clocks before capture.

module adder (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic x5,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic y4,
    input  logic y5,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic s5,
    output logic s6
);
    logic c1, c2, c3, c4, c5;

    assign s0 = x0 ^ y0;
    assign c1 = x0 & y0;
    assign s1 = x1 ^ y1 ^ c1;
    assign c2 = (x1 & y1) | (c1 & (x1 ^ y1));
    assign s2 = x2 ^ y2 ^ c2;
    assign c3 = (x2 & y2) | (c2 & (x2 ^ y2));
    assign s3 = x3 ^ y3 ^ c3;
    assign c4 = (x3 & y3) | (c3 & (x3 ^ y3));
    assign s4 = x4 ^ y4 ^ c4;
    assign c5 = (x4 & y4) | (c4 & (x4 ^ y4));
    assign s5 = x5 ^ y5 ^ c5;
    assign s6 = (x5 & y5) | (c5 & (x5 ^ y5));
endmodule

module adder_share_ctrl #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = $clog2(N_REQ),
    parameter int ADD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [6*N_REQ-1:0]   x_bus,
    input  logic [6*N_REQ-1:0]   y_bus,
    output logic [N_REQ-1:0]     gnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [6:0]           rsp_sum,
    output logic                 busy
);
    localparam int CntW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StEval, StHold} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [5:0]      op_x_q, op_x_d;
    logic [5:0]      op_y_q, op_y_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [6:0]      rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic [5:0]      pick_x, pick_y;
    logic [6:0]      add_s;

    // Adder sees only the registered operands, so bus changes after grant cannot disturb it.
    adder u_adder (
        .x0 (op_x_q[0]), .x1 (op_x_q[1]), .x2 (op_x_q[2]),
        .x3 (op_x_q[3]), .x4 (op_x_q[4]), .x5 (op_x_q[5]),
        .y0 (op_y_q[0]), .y1 (op_y_q[1]), .y2 (op_y_q[2]),
        .y3 (op_y_q[3]), .y4 (op_y_q[4]), .y5 (op_y_q[5]),
        .s0 (add_s[0]),  .s1 (add_s[1]),  .s2 (add_s[2]),
        .s3 (add_s[3]),  .s4 (add_s[4]),  .s5 (add_s[5]),
        .s6 (add_s[6])
    );

    // Two passes: indices at/above rr_ptr first, then wrap around from 0.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        pick_x   = '0;
        pick_y   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!pick_any && req[j] && (j >= int'(rr_ptr_q))) begin
                pick_any = 1'b1;
                pick_idx = ID_W'(j);
                pick_x   = x_bus[6*j +: 6];
                pick_y   = y_bus[6*j +: 6];
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!pick_any && req[j]) begin
                pick_any = 1'b1;
                pick_idx = ID_W'(j);
                pick_x   = x_bus[6*j +: 6];
                pick_y   = y_bus[6*j +: 6];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        gnt         = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt[pick_idx] = 1'b1;
                    op_x_d        = pick_x;
                    op_y_d        = pick_y;
                    rsp_id_d      = pick_idx;
                    rr_ptr_d      = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
                    cnt_d         = CntW'(ADD_CYCLES - 1);
                    state_d       = StEval;
                end
            end
            StEval: begin
                if (cnt_q == '0) begin
                    rsp_sum_d   = add_s;
                    rsp_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != StIdle);
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed self-checking bench for adder_share_ctrl (N_REQ=4, ADD_CYCLES=2).
// Inputs change and outputs are sampled around the falling edge.

module tb_adder_share_ctrl;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [23:0] x_bus;
    logic [23:0] y_bus;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [6:0]  rsp_sum;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    adder_share_ctrl #(
        .N_REQ      (4),
        .ID_W       (2),
        .ADD_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_bus     (x_bus),
        .y_bus     (y_bus),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        rsp_ready = 1'b1;
        x_bus     = '0;
        y_bus     = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns 1ns after the falling edge where gnt is first nonzero.
    task automatic wait_gnt(output bit to);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (gnt !== 4'b0000) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output bit to);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out, got no event, required one within budget", name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0001;
        rsp_ready = 1'b1;
        x_bus = '0;
        y_bus = '0;
        @(negedge clk);
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b required 0", rsp_valid);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        n_tests++;
        if (gnt !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gnt: got %b required 0000", gnt);
        end
        n_tests++;
        if (rsp_sum !== 7'd0 || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_rsp: got sum %0d id %0d required 0 0", rsp_sum, rsp_id);
        end
    endtask

    task automatic test_single();
        bit to;
        req = 4'b0001;
        x_bus[0 +: 6] = 6'd63;
        y_bus[0 +: 6] = 6'd1;
        wait_gnt(to);
        if (to) begin timeout_fail("single_gnt"); return; end
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL single_gnt: got %b required 0001", gnt);
        end
        @(negedge clk);
        req = '0;
        #1;
        n_tests++;
        if ({gnt, busy, rsp_valid} !== {4'b0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_eval1: got gnt %b busy %b valid %b required 0000 1 0",
                     gnt, busy, rsp_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_eval2: got valid %b required 0", rsp_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({rsp_valid, rsp_sum, rsp_id} !== {1'b1, 7'b1000000, 2'd0}) begin
            n_fail++;
            $display("FAIL single_rsp: got valid %b sum %b id %0d required 1 1000000 0",
                     rsp_valid, rsp_sum, rsp_id);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_idle: got valid %b busy %b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_all_request();
        bit to;
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int xs[4]     = '{10, 20, 33, 63};
        int ys[4]     = '{5, 44, 31, 63};
        int sums[4]   = '{15, 64, 64, 126};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            x_bus[6*i +: 6] = 6'(xs[i]);
            y_bus[6*i +: 6] = 6'(ys[i]);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(to);
            if (to) begin timeout_fail("all_gnt"); return; end
            n_tests++;
            if (gnt !== 4'(1 << exp_id[k])) begin
                n_fail++; $display("FAIL all_gnt[%0d]: got %b required id %0d", k, gnt, exp_id[k]);
            end
            @(negedge clk);
            wait_valid(to);
            if (to) begin timeout_fail("all_valid"); return; end
            n_tests++;
            if ({rsp_sum, rsp_id} !== {7'(sums[exp_id[k]]), 2'(exp_id[k])}) begin
                n_fail++;
                $display("FAIL all_rsp[%0d]: got sum %0d id %0d required sum %0d id %0d",
                         k, rsp_sum, rsp_id, sums[exp_id[k]], exp_id[k]);
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        rsp_ready = 1'b0;
        x_bus[6 +: 6] = 6'd7;
        y_bus[6 +: 6] = 6'd9;
        req = 4'b0010;
        wait_gnt(to);
        if (to) begin timeout_fail("bp_gnt"); return; end
        @(negedge clk);
        wait_valid(to);
        if (to) begin timeout_fail("bp_valid"); return; end
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if ({rsp_valid, rsp_sum, rsp_id, gnt, busy} !==
                {1'b1, 7'd16, 2'd1, 4'b0000, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid %b sum %0d id %0d gnt %b busy %b required 1 16 1 0000 1",
                         c, rsp_valid, rsp_sum, rsp_id, gnt, busy);
            end
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({rsp_valid, busy, gnt} !== {1'b0, 1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL bp_release: got valid %b busy %b gnt %b required 0 0 0010",
                     rsp_valid, busy, gnt);
        end
        @(negedge clk);
        req = '0;
        wait_valid(to);
        if (to) begin timeout_fail("bp_valid2"); return; end
        n_tests++;
        if (rsp_sum !== 7'd16) begin
            n_fail++; $display("FAIL bp_sum2: got %0d required 16", rsp_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit to;
        do_reset();
        x_bus[12 +: 6] = 6'd50;
        y_bus[12 +: 6] = 6'd27;
        req = 4'b0100;
        wait_gnt(to);
        if (to) begin timeout_fail("mid_gnt"); return; end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, busy, gnt} !== {1'b0, 1'b0, 4'b0100}) begin
            n_fail++;
            $display("FAIL mid_after_rst: got valid %b busy %b gnt %b required 0 0 0100",
                     rsp_valid, busy, gnt);
        end
        @(negedge clk);
        req = '0;
        wait_valid(to);
        if (to) begin timeout_fail("mid_valid"); return; end
        n_tests++;
        if ({rsp_sum, rsp_id} !== {7'd77, 2'd2}) begin
            n_fail++; $display("FAIL mid_rsp: got sum %0d id %0d required 77 2", rsp_sum, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        bit to;
        int bad = 0;
        do_reset();
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                x_bus[12 +: 6] = 6'(x);
                y_bus[12 +: 6] = 6'(y);
                req = 4'b0100;
                wait_gnt(to);
                if (to) begin timeout_fail("exh_gnt"); return; end
                @(negedge clk);
                req = '0;
                x_bus[12 +: 6] = ~6'(x);
                y_bus[12 +: 6] = ~6'(y);
                wait_valid(to);
                if (to) begin timeout_fail("exh_valid"); return; end
                n_tests++;
                if ({rsp_sum, rsp_id} !== {7'(x + y), 2'd2}) begin
                    n_fail++;
                    bad++;
                    if (bad <= 20)
                        $display("FAIL exh x=%0d y=%0d: got sum %0d id %0d required %0d 2",
                                 x, y, rsp_sum, rsp_id, x + y);
                end
            end
        end
    endtask

    task automatic test_fairness();
        bit to;
        int since = -1;
        bit got3 = 1'b0;
        do_reset();
        x_bus[0 +: 6]  = 6'd1;
        y_bus[0 +: 6]  = 6'd1;
        x_bus[18 +: 6] = 6'd5;
        y_bus[18 +: 6] = 6'd6;
        req = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin
                req[3] = 1'b1;
                since  = 0;
            end
            wait_gnt(to);
            if (to) begin timeout_fail("fair_gnt"); return; end
            n_tests++;
            if (((gnt & ~req) !== 4'b0000) || !$onehot(gnt)) begin
                n_fail++; $display("FAIL fair_legal[%0d]: got gnt %b with req %b", k, gnt, req);
            end
            if (since >= 0 && !got3) since++;
            if (gnt[3] === 1'b1) begin
                got3 = 1'b1;
                n_tests++;
                if (since > 4) begin
                    n_fail++; $display("FAIL fair_latency: got %0d grants required <= 4", since);
                end
            end
            @(negedge clk);
            if (gnt === 4'b0000 && got3) req[3] = 1'b0;
            wait_valid(to);
            if (to) begin timeout_fail("fair_valid"); return; end
            n_tests++;
            if (rsp_sum !== ((rsp_id == 2'd3) ? 7'd11 : 7'd2)) begin
                n_fail++; $display("FAIL fair_sum[%0d]: got %0d for id %0d", k, rsp_sum, rsp_id);
            end
        end
        n_tests++;
        if (!got3) begin
            n_fail++; $display("FAIL fair_req3: got no grant to requester 3, required one");
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        rsp_ready = 1'b1;
        x_bus     = '0;
        y_bus     = '0;
        test_reset();
        test_single();
        test_all_request();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        test_fairness();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
